// File: rtl/regfile_writeback_sequencer.sv
// Drains one warp result bundle into the register file's single write port, one thread per step.
// WB_SKIP_INACTIVE_EN: define to skip inactive threads; leave undefined for a fixed NUM_THREADS-cycle scan.
module regfile_writeback_sequencer #(
  parameter int NUM_THREADS    = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [REG_ADDR_WIDTH-1:0]           in_rd,
  input  logic [NUM_THREADS-1:0]              in_mask,
  input  logic [NUM_THREADS*DATA_WIDTH-1:0]   in_data,
  output logic                                we,
  output logic [REG_ADDR_WIDTH-1:0]           wr_addr,
  output logic [DATA_WIDTH-1:0]               wr_data,
  output logic [$clog2(NUM_THREADS)-1:0]      wr_thread,
  output logic                                busy,
  output logic                                done
);
  localparam int TW = $clog2(NUM_THREADS);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                            state_reg;
  logic [NUM_THREADS-1:0]            rem_reg;
  logic [REG_ADDR_WIDTH-1:0]         rd_reg;
  logic [NUM_THREADS*DATA_WIDTH-1:0] data_reg;
  logic                              we_reg;
  logic                              done_reg;
  logic [REG_ADDR_WIDTH-1:0]         wr_addr_reg;
  logic [DATA_WIDTH-1:0]             wr_data_reg;
  logic [TW-1:0]                     wr_thread_reg;

  logic                              transfer;
  logic                              writable;
  logic                              advance;
  logic [NUM_THREADS-1:0]            src_mask;
  logic [REG_ADDR_WIDTH-1:0]         src_rd;
  logic [NUM_THREADS*DATA_WIDTH-1:0] src_data;
  logic [NUM_THREADS-1:0]            rem_next;
  logic [TW-1:0]                     sel_idx;
  logic                              sel_valid;
  logic                              sel_last;

  // done_reg marks the final step of the bundle currently on the outputs.
  assign in_ready  = (state_reg == IDLE) || done_reg;
  assign transfer  = in_valid && in_ready;
  assign writable  = (in_rd != '0) && (in_rd <= REG_ADDR_WIDTH'(27));
  assign advance   = transfer || ((state_reg == DRAIN) && !done_reg);
  assign busy      = (state_reg == DRAIN);
  assign we        = we_reg;
  assign done      = done_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;
  assign wr_thread = wr_thread_reg;

  // A new bundle is presented straight from the inputs so its first step lands one cycle after acceptance.
  always_comb begin
    src_mask = rem_reg;
    src_rd   = rd_reg;
    src_data = data_reg;
    if (transfer) begin
      src_mask = writable ? in_mask : '0;
      src_rd   = in_rd;
      src_data = in_data;
    end
  end

`ifdef WB_SKIP_INACTIVE_EN
  always_comb begin
    sel_idx   = '0;
    sel_valid = 1'b0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (src_mask[i]) begin
        sel_idx   = TW'(i);
        sel_valid = 1'b1;
      end
    end
    rem_next = src_mask;
    if (sel_valid) rem_next[sel_idx] = 1'b0;
    sel_last = (rem_next == '0);
  end
`else
  logic [TW-1:0] cnt_reg;

  always_comb begin
    sel_idx   = transfer ? '0 : cnt_reg + TW'(1);
    sel_valid = src_mask[sel_idx];
    rem_next  = src_mask;
    rem_next[sel_idx] = 1'b0;
    sel_last  = (sel_idx == TW'(NUM_THREADS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_reg <= '0;
    else if (advance) cnt_reg <= sel_idx;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rem_reg       <= '0;
      rd_reg        <= '0;
      data_reg      <= '0;
      we_reg        <= 1'b0;
      done_reg      <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      wr_thread_reg <= '0;
    end else if (advance) begin
      state_reg <= DRAIN;
      rem_reg   <= rem_next;
      if (transfer) begin
        rd_reg   <= in_rd;
        data_reg <= in_data;
      end
      we_reg   <= sel_valid;
      done_reg <= sel_last;
      // Address, data and thread hold their last values on non-writing steps.
      if (sel_valid) begin
        wr_addr_reg   <= src_rd;
        wr_data_reg   <= src_data[sel_idx*DATA_WIDTH +: DATA_WIDTH];
        wr_thread_reg <= sel_idx;
      end
    end else begin
      state_reg <= IDLE;
      we_reg    <= 1'b0;
      done_reg  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_writeback_sequencer.sv
// Scoreboard bench: the stimulus queues expected writes and drain lengths, a negedge monitor checks them.
module tb_regfile_writeback_sequencer;
  localparam int NT = 16;
  localparam int DW = 32;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [AW-1:0]     in_rd = '0;
  logic [NT-1:0]     in_mask = '0;
  logic [NT*DW-1:0]  in_data = '0;
  logic              we;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [3:0]        wr_thread;
  logic              busy;
  logic              done;

  typedef struct {
    int        thr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  len_q[$];
  int  tests = 0;
  int  fails = 0;
  int  drain_cnt = 0;

  regfile_writeback_sequencer #(.NUM_THREADS(NT), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_mask(in_mask), .in_data(in_data),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_thread(wr_thread),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill(input logic [DW-1:0] base);
    for (int i = 0; i < NT; i++) in_data[i*DW +: DW] = base + DW'(i);
  endtask

  // Offer a bundle; with noise set, drive changing junk while the DUT is not ready.
  task automatic send(input logic [AW-1:0] rd, input logic [NT-1:0] mask,
                      input logic [DW-1:0] base, input bit noise);
    logic [NT-1:0] eff;
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      if (in_ready || !noise) begin
        in_rd = rd; in_mask = mask; fill(base);
      end else begin
        in_rd = AW'(12 + c); in_mask = ~NT'(c); fill(32'hBAD0_0000 + DW'(c) * 32'h100);
      end
      if (in_ready) begin
        eff = (rd >= 1 && rd <= 27) ? mask : '0;
        for (int i = 0; i < NT; i++)
          if (eff[i]) exp_q.push_back('{thr: i, addr: rd, data: base + DW'(i)});
`ifdef WB_SKIP_INACTIVE_EN
        len_q.push_back(($countones(eff) == 0) ? 1 : $countones(eff));
`else
        len_q.push_back(NT);
`endif
        ok = 1'b1;
        @(posedge clk);
      end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready never 1 for rd=%0d", rd);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    check("drain_finish", {63'd0, ok}, 64'd1);
  endtask

  // Monitor: every write must match the head of the scoreboard; every done closes a bundle of known length.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        drain_cnt = 0;
      end else begin
        if (busy) drain_cnt++;
        if (we) begin
          check("we_implies_busy", {63'd0, busy}, 64'd1);
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_write: thread=%0d addr=%0d data=%0h expected no write",
                     wr_thread, wr_addr, wr_data);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_thread", {60'd0, wr_thread}, 64'(e.thr));
            check("wr_addr", {59'd0, wr_addr}, {59'd0, e.addr});
            check("wr_data", {32'd0, wr_data}, {32'd0, e.data});
            $display("[TB] write t%0d addr=%0d data=%0h", wr_thread, wr_addr, wr_data);
          end
        end
        if (done) begin
          if (len_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_done: got done expected none");
          end else begin
            int l;
            l = len_q.pop_front();
            check("drain_length", 64'(drain_cnt), 64'(l));
            $display("[TB] bundle done after %0d cycles", drain_cnt);
          end
          drain_cnt = 0;
        end
      end
    end
  end

  initial begin
    bit found;
    #1;
    check("rst_we", {63'd0, we}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_wr_data", {32'd0, wr_data}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Four sparse threads; bit 0 is active so the first step writes in both modes.
    send(5'd5, 16'h8421, 32'h100, 1'b0);
    #1;
    check("lat_busy", {63'd0, busy}, 64'd1);
    check("lat_we", {63'd0, we}, 64'd1);
    check("lat_thread", {60'd0, wr_thread}, 64'd0);
    check("lat_data", {32'd0, wr_data}, 64'h100);
    wait_idle();

    // Back-to-back, second bundle held stable until accepted.
    send(5'd3, 16'h0003, 32'h300, 1'b0);
    send(5'd4, 16'h0001, 32'h400, 1'b0);
    wait_idle();

    // Non-writable and boundary destinations, plus an empty mask.
    send(5'd0, 16'hFFFF, 32'h500, 1'b0);
    send(5'd29, 16'hFFFF, 32'h600, 1'b0);
    send(5'd28, 16'h0001, 32'h680, 1'b0);
    send(5'd27, 16'h0100, 32'h700, 1'b0);
    send(5'd1, 16'h8000, 32'h800, 1'b0);
    send(5'd6, 16'h0000, 32'h880, 1'b0);
    wait_idle();

    send(5'd7, 16'h0002, 32'h900, 1'b0);
    wait_idle();

    // Junk offered while draining must never be written.
    send(5'd11, 16'h00FF, 32'hA00, 1'b0);
    send(5'd10, 16'h0C00, 32'hB00, 1'b1);
    wait_idle();

    // Reset at the second write of a four-write bundle.
    send(5'd9, 16'h00F0, 32'hC00, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (we && wr_thread == 4'd5) found = 1'b1;
      else @(negedge clk);
    end
    check("second_write_seen", {63'd0, found}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_we", {63'd0, we}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_thread", {60'd0, wr_thread}, 64'd0);
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    exp_q.delete();
    len_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", {63'd0, in_ready}, 64'd1);
    send(5'd2, 16'h0011, 32'hD00, 1'b0);
    wait_idle();

    repeat (3) @(negedge clk);
    check("writes_left", 64'(exp_q.size()), 64'd0);
    check("bundles_left", 64'(len_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
